// File: rtl/uart_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_io_ctrl
//  Purpose  : Sequences byte-wide CPU loads/stores onto a UART FIFO pair.
//             Address 0 is the data register (push TX / pop RX), address 1
//             is the status register {tx_full, rx_empty}. Every FIFO wait is
//             bounded by a cycle timeout that completes the access with an
//             error flag instead of stalling the CPU forever.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_io_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_req,
    input  logic       io_we,
    input  logic       io_addr,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    output logic       io_ack,
    output logic       io_err,
    output logic       io_busy,
    output logic       uart_rd,
    output logic       uart_wr,
    output logic [7:0] uart_wdata,
    input  logic [7:0] uart_rdata,
    input  logic       tx_full,
    input  logic       rx_empty
);

    // Counter must be able to hold TIMEOUT_CYCLES itself.
    localparam int                 c_CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic               c_TMO_EN   = (TIMEOUT_CYCLES != 0);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_STATUS   = 3'd1;
    localparam logic [2:0] c_ST_WAIT_TX  = 3'd2;
    localparam logic [2:0] c_ST_WR_PULSE = 3'd3;
    localparam logic [2:0] c_ST_WAIT_RX  = 3'd4;
    localparam logic [2:0] c_ST_RD_PULSE = 3'd5;
    localparam logic [2:0] c_ST_DONE     = 3'd6;

    logic [2:0]         r_state;
    logic               r_we;
    logic [7:0]         r_wdata;
    logic [c_CNT_W-1:0] r_timeoutCnt;

    logic [2:0]         w_nextState;
    logic               w_nextWe;
    logic [7:0]         w_nextWdata;
    logic [c_CNT_W-1:0] w_nextCnt;
    logic [7:0]         w_nextRdata;
    logic               w_nextAck;
    logic               w_nextErr;
    logic               w_nextUartRd;
    logic               w_nextUartWr;
    logic [7:0]         w_nextUartWdata;
    logic               w_timeoutHit;

    // A wait gives up once the counter has seen TIMEOUT_CYCLES stalled cycles
    // and the FIFO is still not ready, landing the ack at TIMEOUT_CYCLES+2.
    assign w_timeoutHit = c_TMO_EN && (r_timeoutCnt == c_TMO_LAST);

    assign io_busy = (r_state != c_ST_IDLE);

    // Next-state and next-output decode; every pulse is scheduled one state
    // ahead so that the registered outputs line up with their state.
    always_comb begin
        w_nextState     = r_state;
        w_nextWe        = r_we;
        w_nextWdata     = r_wdata;
        w_nextCnt       = r_timeoutCnt;
        w_nextRdata     = io_rdata;
        w_nextAck       = 1'b0;
        w_nextErr       = 1'b0;
        w_nextUartRd    = 1'b0;
        w_nextUartWr    = 1'b0;
        w_nextUartWdata = uart_wdata;

        case (r_state)
            c_ST_IDLE: begin
                if (io_req) begin
                    w_nextWe    = io_we;
                    w_nextWdata = io_wdata;
                    w_nextCnt   = '0;
                    if (io_addr)
                        w_nextState = c_ST_STATUS;
                    else if (io_we)
                        w_nextState = c_ST_WAIT_TX;
                    else
                        w_nextState = c_ST_WAIT_RX;
                end
            end

            c_ST_STATUS: begin
                // Writes to the status register are accepted and dropped.
                if (!r_we)
                    w_nextRdata = {6'b0, tx_full, rx_empty};
                w_nextAck   = 1'b1;
                w_nextState = c_ST_DONE;
            end

            c_ST_WAIT_TX: begin
                if (!tx_full) begin
                    w_nextUartWdata = r_wdata;
                    w_nextUartWr    = 1'b1;
                    w_nextState     = c_ST_WR_PULSE;
                end else if (w_timeoutHit) begin
                    w_nextErr   = 1'b1;
                    w_nextAck   = 1'b1;
                    w_nextState = c_ST_DONE;
                end else if (c_TMO_EN) begin
                    w_nextCnt = r_timeoutCnt + 1'b1;
                end
            end

            c_ST_WR_PULSE: begin
                w_nextAck   = 1'b1;
                w_nextState = c_ST_DONE;
            end

            c_ST_WAIT_RX: begin
                // The RX head is captured here; the pop follows a cycle later.
                if (!rx_empty) begin
                    w_nextRdata  = uart_rdata;
                    w_nextUartRd = 1'b1;
                    w_nextState  = c_ST_RD_PULSE;
                end else if (w_timeoutHit) begin
                    w_nextRdata = 8'h00;
                    w_nextErr   = 1'b1;
                    w_nextAck   = 1'b1;
                    w_nextState = c_ST_DONE;
                end else if (c_TMO_EN) begin
                    w_nextCnt = r_timeoutCnt + 1'b1;
                end
            end

            c_ST_RD_PULSE: begin
                w_nextAck   = 1'b1;
                w_nextState = c_ST_DONE;
            end

            c_ST_DONE: begin
                w_nextState = c_ST_IDLE;
            end

            default: begin
                w_nextState = c_ST_IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs; reset aborts any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_we         <= 1'b0;
            r_wdata      <= 8'h00;
            r_timeoutCnt <= '0;
            io_rdata     <= 8'h00;
            io_ack       <= 1'b0;
            io_err       <= 1'b0;
            uart_rd      <= 1'b0;
            uart_wr      <= 1'b0;
            uart_wdata   <= 8'h00;
        end else begin
            r_state      <= w_nextState;
            r_we         <= w_nextWe;
            r_wdata      <= w_nextWdata;
            r_timeoutCnt <= w_nextCnt;
            io_rdata     <= w_nextRdata;
            io_ack       <= w_nextAck;
            io_err       <= w_nextErr;
            uart_rd      <= w_nextUartRd;
            uart_wr      <= w_nextUartWr;
            uart_wdata   <= w_nextUartWdata;
        end
    end

endmodule
`default_nettype wire
